// File: rtl/load_data.sv
// Packs tagged 32-bit input words into rate-sized ASCON blocks and applies 10* padding.
// The optional protocol checker is enabled with the LOAD_DATA_PROTO_CHECK_EN macro.
module load_data #(
    parameter int unsigned RATE_WORDS_MAX = 4,
    parameter logic [7:0]  PAD_BYTE       = 8'h80
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clr_i,
    input  logic [2:0]                    run_mode_i,
    input  logic                          bdi_valid_i,
    output logic                          bdi_ready_o,
    input  logic [31:0]                   bdi_data_i,
    input  logic [3:0]                    bdi_vld_byte_i,
    input  logic [2:0]                    bdi_type_i,
    input  logic                          bdi_last_i,
    output logic                          blk_valid_o,
    input  logic                          blk_ready_i,
    output logic [32*RATE_WORDS_MAX-1:0]  blk_data_o,
    output logic [4*RATE_WORDS_MAX-1:0]   blk_vld_byte_o,
    output logic [2:0]                    blk_type_o,
    output logic                          blk_last_o,
    output logic                          err_o
);

    localparam int unsigned DW         = 32 * RATE_WORDS_MAX;
    localparam int unsigned VW         = 4 * RATE_WORDS_MAX;
    localparam logic [2:0]  ASCON_128A = 3'd2;
    localparam logic [2:0]  D_NULL     = 3'd0;

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_HOLD   = 2'd1,
        S_PADBLK = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [1:0]      r_word_cnt;
    logic            r_rate4;
    logic            r_extra;
    logic [DW-1:0]   r_data;
    logic [VW-1:0]   r_vld;
    logic [2:0]      r_type;
    logic            r_last;

    logic            w_accept;
    logic            w_first;
    logic            w_rate4;
    logic            w_last_slot;
    logic            w_close;
    logic            w_full;
    logic            w_extra;
    logic [1:0]      w_phys;
    logic [1:0]      w_phys_nxt;
    logic [31:0]     w_mask;
    logic [31:0]     w_pad_in;
    logic [31:0]     w_word;
    logic [31:0]     w_pad_slot;
    logic [DW-1:0]   w_data_next;
    logic [VW-1:0]   w_vld_next;
    logic [DW-1:0]   w_pad_blk;

    assign w_accept    = bdi_valid_i & (r_state == S_FILL);
    assign w_first     = (r_word_cnt == 2'd0);
    assign w_rate4     = w_first ? (run_mode_i == ASCON_128A) : r_rate4;
    assign w_last_slot = w_rate4 ? (r_word_cnt == 2'd3) : (r_word_cnt == 2'd1);
    assign w_close     = bdi_last_i | w_last_slot;
    assign w_extra     = bdi_last_i & w_full & w_last_slot;
    // Slot k lands at physical word (rate-1-k) so the first word sits at the block MSBs.
    assign w_phys      = w_rate4 ? (2'd3 - r_word_cnt) : (2'd1 - r_word_cnt);
    assign w_phys_nxt  = w_phys - 2'd1;
    assign w_mask      = {{8{bdi_vld_byte_i[3]}}, {8{bdi_vld_byte_i[2]}},
                          {8{bdi_vld_byte_i[1]}}, {8{bdi_vld_byte_i[0]}}};

    // Decode where the pad byte falls inside a partial closing word.
    always_comb begin
        w_full   = 1'b0;
        w_pad_in = 32'h0;
        case (bdi_vld_byte_i)
            4'hF:    w_full   = 1'b1;
            4'hE:    w_pad_in = {24'h0, PAD_BYTE};
            4'hC:    w_pad_in = {16'h0, PAD_BYTE, 8'h0};
            4'h8:    w_pad_in = {8'h0, PAD_BYTE, 16'h0};
            default: w_full   = 1'b1;
        endcase
    end

    // Merge the accepted word (and a following pad word) into the block image.
    always_comb begin
        w_word      = (bdi_data_i & w_mask) | (bdi_last_i ? w_pad_in : 32'h0);
        w_pad_slot  = (bdi_last_i && w_full && !w_last_slot) ? {PAD_BYTE, 24'h0} : 32'h0;
        w_data_next = (w_first ? {DW{1'b0}} : r_data)
                    | ({{(DW-32){1'b0}}, w_word} << {w_phys, 5'd0})
                    | ({{(DW-32){1'b0}}, w_pad_slot} << {w_phys_nxt, 5'd0});
        w_vld_next  = (w_first ? {VW{1'b0}} : r_vld)
                    | ({{(VW-4){1'b0}}, bdi_vld_byte_i} << {w_phys, 2'd0});
        w_pad_blk   = {{(DW-8){1'b0}}, PAD_BYTE} << (r_rate4 ? 7'd120 : 7'd56);
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FILL:   w_state_next = (w_accept && w_close) ? S_HOLD : S_FILL;
            S_HOLD:   w_state_next = blk_ready_i ? (r_extra ? S_PADBLK : S_FILL) : S_HOLD;
            S_PADBLK: w_state_next = S_HOLD;
            default:  w_state_next = S_FILL;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        bdi_ready_o = 1'b0;
        blk_valid_o = 1'b0;
        case (r_state)
            S_FILL:   bdi_ready_o = 1'b1;
            S_HOLD:   blk_valid_o = 1'b1;
            S_PADBLK: blk_valid_o = 1'b0;
            default:  bdi_ready_o = 1'b0;
        endcase
    end

    // Block register, word counter and per-block attributes.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_word_cnt <= 2'd0;
            r_rate4    <= 1'b0;
            r_extra    <= 1'b0;
            r_data     <= {DW{1'b0}};
            r_vld      <= {VW{1'b0}};
            r_type     <= D_NULL;
            r_last     <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_data     <= w_data_next;
                        r_vld      <= w_vld_next;
                        r_rate4    <= w_rate4;
                        r_type     <= w_first ? bdi_type_i : r_type;
                        r_word_cnt <= w_close ? 2'd0 : (r_word_cnt + 2'd1);
                        r_last     <= w_close & bdi_last_i & ~w_extra;
                        r_extra    <= w_extra;
                    end
                end
                S_PADBLK: begin
                    r_data  <= w_pad_blk;
                    r_vld   <= {VW{1'b0}};
                    r_last  <= 1'b1;
                    r_extra <= 1'b0;
                end
                default: begin
                    r_data <= r_data;
                end
            endcase
        end
    end

    assign blk_data_o     = r_data;
    assign blk_vld_byte_o = r_vld;
    assign blk_type_o     = r_type;
    assign blk_last_o     = r_last;

`ifdef LOAD_DATA_PROTO_CHECK_EN
    logic r_err;
    logic w_vld_bad;

    // Only MSB-aligned byte-valid patterns are legal.
    always_comb begin
        w_vld_bad = 1'b1;
        case (bdi_vld_byte_i)
            4'hF, 4'hE, 4'hC, 4'h8: w_vld_bad = 1'b0;
            default:                w_vld_bad = 1'b1;
        endcase
    end

    // Sticky protocol error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_err <= 1'b0;
        end else if (w_accept && (w_vld_bad ||
                                  ((bdi_vld_byte_i != 4'hF) && !bdi_last_i) ||
                                  (!w_first && (bdi_type_i != r_type)))) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_load_data.sv
// Self-checking bench for load_data: directed vector table, corner sequences and a
// randomized run checked against a byte-level padding model.
module tb_load_data;

    localparam logic [2:0] M128   = 3'd1;
    localparam logic [2:0] M128A  = 3'd2;
    localparam logic [2:0] MHASH  = 3'd3;
    localparam logic [2:0] D_AD   = 3'd1;
    localparam logic [2:0] D_TEXT = 3'd2;
    localparam logic [2:0] D_HASH = 3'd3;

    logic         clk_i = 1'b0;
    logic         rst_i, clr_i;
    logic [2:0]   run_mode_i;
    logic         bdi_valid_i, bdi_ready_o;
    logic [31:0]  bdi_data_i;
    logic [3:0]   bdi_vld_byte_i;
    logic [2:0]   bdi_type_i;
    logic         bdi_last_i;
    logic         blk_valid_o, blk_ready_i;
    logic [127:0] blk_data_o;
    logic [15:0]  blk_vld_byte_o;
    logic [2:0]   blk_type_o;
    logic         blk_last_o;
    logic         err_o;

    load_data dut (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .run_mode_i(run_mode_i),
        .bdi_valid_i(bdi_valid_i), .bdi_ready_o(bdi_ready_o), .bdi_data_i(bdi_data_i),
        .bdi_vld_byte_i(bdi_vld_byte_i), .bdi_type_i(bdi_type_i), .bdi_last_i(bdi_last_i),
        .blk_valid_o(blk_valid_o), .blk_ready_i(blk_ready_i), .blk_data_o(blk_data_o),
        .blk_vld_byte_o(blk_vld_byte_o), .blk_type_o(blk_type_o), .blk_last_o(blk_last_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]   m;
        logic [2:0]   t;
        int           nw;
        logic [127:0] w;
        logic [15:0]  v;
        logic [127:0] ed;
        logic [15:0]  ev;
        logic         el;
        logic         ex;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  v;
        logic        l;
        logic [2:0]  m;
        logic [2:0]  t;
    } word_t;

    typedef struct {
        logic [127:0] d;
        logic [15:0]  v;
        logic [2:0]   t;
        logic         l;
    } blk_t;

    vec_t  tbl[8];
    word_t wq[$];
    blk_t  bq[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] v, input logic l,
                             input logic [2:0] m, input logic [2:0] t);
        int to;
        bdi_data_i = d; bdi_vld_byte_i = v; bdi_last_i = l;
        run_mode_i = m; bdi_type_i = t; bdi_valid_i = 1'b1;
        to = 0;
        while (!bdi_ready_o && to < 200) begin
            @(posedge clk_i); #1; to++;
        end
        if (to >= 200) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: bdi_ready_o got 0 expected 1");
            bdi_valid_i = 1'b0;
        end else begin
            @(posedge clk_i); #1;
            bdi_valid_i = 1'b0;
        end
    endtask

    task automatic recv_block(input string nm, input logic [127:0] ed, input logic [15:0] ev,
                              input logic [2:0] et, input logic el, input int dly);
        int to;
        to = 0;
        while (!blk_valid_o && to < 200) begin
            @(posedge clk_i); #1; to++;
        end
        if (to >= 200) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: blk_valid_o got 0 expected 1", nm);
        end else begin
            chk({nm, "_data"}, blk_data_o, ed);
            chk({nm, "_vld"},  {112'h0, blk_vld_byte_o}, {112'h0, ev});
            chk({nm, "_type"}, {125'h0, blk_type_o}, {125'h0, et});
            chk({nm, "_last"}, {127'h0, blk_last_o}, {127'h0, el});
            repeat (dly) begin @(posedge clk_i); #1; end
            blk_ready_i = 1'b1;
            @(posedge clk_i); #1;
            blk_ready_i = 1'b0;
        end
    endtask

    // Byte-level reference: message bytes, one pad byte, zero fill to the rate.
    task automatic model_segment(input logic [2:0] m, input logic [2:0] t, input int nw);
        logic [7:0]  bytes_q[$];
        logic [31:0] d;
        logic [3:0]  v;
        int          nv, len, rb, nb;
        blk_t        b;
        rb = (m == M128A) ? 16 : 8;
        for (int i = 0; i < nw; i++) begin
            d = $urandom();
            if (i == nw - 1) begin
                case ($urandom_range(0, 3))
                    0: begin v = 4'hF; nv = 4; end
                    1: begin v = 4'hE; nv = 3; end
                    2: begin v = 4'hC; nv = 2; end
                    default: begin v = 4'h8; nv = 1; end
                endcase
            end else begin
                v = 4'hF; nv = 4;
            end
            wq.push_back('{d, v, (i == nw - 1), m, t});
            for (int k = 0; k < nv; k++) bytes_q.push_back(d[31-8*k -: 8]);
        end
        len = bytes_q.size();
        bytes_q.push_back(8'h80);
        while ((bytes_q.size() % rb) != 0) bytes_q.push_back(8'h00);
        nb = bytes_q.size() / rb;
        for (int bi = 0; bi < nb; bi++) begin
            b.d = 128'h0; b.v = 16'h0; b.t = t; b.l = (bi == nb - 1);
            for (int j = 0; j < rb; j++) begin
                b.d[8*(rb-1-j) +: 8] = bytes_q[bi*rb + j];
                b.v[rb-1-j] = ((bi*rb + j) < len);
            end
            bq.push_back(b);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pb;
        logic [31:0]  wd;
        logic [3:0]   vd;
        blk_t         eb;
        int           nblk;

        tbl[0] = '{M128,  D_TEXT, 2, {32'h11223344, 32'h55667788, 64'h0}, 16'hFF00,
                   128'h1122334455667788, 16'h00FF, 1'b0, 1'b1};
        tbl[1] = '{M128,  D_HASH, 1, {32'hAABBCCDD, 96'h0}, 16'hC000,
                   128'hAABB800000000000, 16'h00C0, 1'b1, 1'b0};
        tbl[2] = '{M128A, D_TEXT, 3, {32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0}, 16'hFFF0,
                   128'h01020304_05060708_090A0B0C_80000000, 16'hFFF0, 1'b1, 1'b0};
        tbl[3] = '{M128A, D_AD,   4, {32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hDDEEFF11}, 16'hFFFE,
                   128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_DDEEFF80, 16'hFFFE, 1'b1, 1'b0};
        tbl[4] = '{MHASH, D_HASH, 1, {32'hCAFEBABE, 96'h0}, 16'hF000,
                   128'hCAFEBABE80000000, 16'h00F0, 1'b1, 1'b0};
        tbl[5] = '{M128A, D_TEXT, 1, {32'h12345678, 96'h0}, 16'h8000,
                   128'h12800000_00000000_00000000_00000000, 16'h8000, 1'b1, 1'b0};
        tbl[6] = '{M128A, D_TEXT, 4, {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100}, 16'hFFFF,
                   128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'hFFFF, 1'b0, 1'b1};
        tbl[7] = '{M128,  D_AD,   2, {32'h11111111, 32'h22222233, 64'h0}, 16'hFE00,
                   128'h1111111122222280, 16'h00FE, 1'b1, 1'b0};

        rst_i = 1'b1; clr_i = 1'b0; run_mode_i = M128; bdi_valid_i = 1'b0;
        bdi_data_i = 32'h0; bdi_vld_byte_i = 4'h0; bdi_type_i = 3'd0; bdi_last_i = 1'b0;
        blk_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ready", {127'h0, bdi_ready_o}, 128'h1);
        chk("rst_valid", {127'h0, blk_valid_o}, 128'h0);
        chk("rst_last",  {127'h0, blk_last_o}, 128'h0);
        chk("rst_data",  blk_data_o, 128'h0);
        chk("rst_vld",   {112'h0, blk_vld_byte_o}, 128'h0);
        chk("rst_type",  {125'h0, blk_type_o}, 128'h0);
        chk("rst_err",   {127'h0, err_o}, 128'h0);
        rst_i = 1'b0;

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < tbl[k].nw; i++) begin
                wd = tbl[k].w[127-32*i -: 32];
                vd = tbl[k].v[15-4*i -: 4];
                send_word(wd, vd, (i == tbl[k].nw - 1), tbl[k].m, tbl[k].t);
            end
            chk($sformatf("vec%0d_latency", k), {127'h0, blk_valid_o}, 128'h1);
            recv_block($sformatf("vec%0d", k), tbl[k].ed, tbl[k].ev, tbl[k].t, tbl[k].el, k % 3);
            if (tbl[k].ex) begin
                pb = (tbl[k].m == M128A) ? {8'h80, 120'h0} : {64'h0, 8'h80, 56'h0};
                recv_block($sformatf("vec%0d_padblk", k), pb, 16'h0, tbl[k].t, 1'b1, 0);
            end
        end

        // Back-pressure: block held for 5 cycles while the next word waits.
        send_word(32'hDEADBEEF, 4'hF, 1'b1, M128, D_HASH);
        bdi_data_i = 32'h5A000000; bdi_vld_byte_i = 4'h8; bdi_last_i = 1'b1;
        run_mode_i = M128; bdi_type_i = D_TEXT; bdi_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1;
            chk("hold_ready", {127'h0, bdi_ready_o}, 128'h0);
            chk("hold_valid", {127'h0, blk_valid_o}, 128'h1);
            chk("hold_data",  blk_data_o, 128'hDEADBEEF80000000);
        end
        blk_ready_i = 1'b1;
        @(posedge clk_i); #1;
        blk_ready_i = 1'b0;
        chk("resume_ready", {127'h0, bdi_ready_o}, 128'h1);
        chk("resume_valid", {127'h0, blk_valid_o}, 128'h0);
        @(posedge clk_i); #1;
        bdi_valid_i = 1'b0;
        chk("resume_latency", {127'h0, blk_valid_o}, 128'h1);
        recv_block("resume", 128'h5A80000000000000, 16'h0080, D_TEXT, 1'b1, 0);

        // Abort mid-block, then a fresh segment must pack from slot 0.
        send_word(32'h99999999, 4'hF, 1'b0, M128A, D_AD);
        clr_i = 1'b1;
        @(posedge clk_i); #1;
        clr_i = 1'b0;
        chk("clr_ready", {127'h0, bdi_ready_o}, 128'h1);
        chk("clr_valid", {127'h0, blk_valid_o}, 128'h0);
        chk("clr_data",  blk_data_o, 128'h0);
        chk("clr_vld",   {112'h0, blk_vld_byte_o}, 128'h0);
        chk("clr_type",  {125'h0, blk_type_o}, 128'h0);
        send_word(32'h01234567, 4'hF, 1'b0, M128, D_TEXT);
        send_word(32'h89ABCDEF, 4'hC, 1'b1, M128, D_TEXT);
        recv_block("after_clr", 128'h0123456789AB8000, 16'h00FC, D_TEXT, 1'b1, 0);

        // Illegal byte-valid pattern.
        send_word(32'h77777777, 4'h6, 1'b1, M128, D_TEXT);
`ifdef LOAD_DATA_PROTO_CHECK_EN
        chk("err_set", {127'h0, err_o}, 128'h1);
        repeat (3) @(posedge clk_i);
        #1;
        chk("err_sticky", {127'h0, err_o}, 128'h1);
`else
        chk("err_tied", {127'h0, err_o}, 128'h0);
`endif
        clr_i = 1'b1;
        @(posedge clk_i); #1;
        clr_i = 1'b0;
        chk("err_cleared", {127'h0, err_o}, 128'h0);
        chk("err_clr_valid", {127'h0, blk_valid_o}, 128'h0);

        // Randomized segments against the byte-level model.
        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 2))
                0: model_segment(M128,  3'($urandom_range(1, 4)), $urandom_range(1, 9));
                1: model_segment(M128A, 3'($urandom_range(1, 4)), $urandom_range(1, 9));
                default: model_segment(MHASH, D_HASH, $urandom_range(1, 9));
            endcase
        end
        nblk = bq.size();
        fork
            begin
                while (wq.size() > 0) begin
                    word_t w;
                    w = wq.pop_front();
                    send_word(w.d, w.v, w.l, w.m, w.t);
                end
            end
            begin
                for (int b = 0; b < nblk; b++) begin
                    eb = bq.pop_front();
                    recv_block($sformatf("rand_blk%0d", b), eb.d, eb.v, eb.t, eb.l,
                               $urandom_range(0, 3));
                end
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/load_data.md
Name: load_data

Overview:
- Input-side counterpart of the result packer in the ASCON datapath.
- Accepts 32-bit bus words tagged {type, valid bytes, last} from the host-side input interface.
- Packs them into rate-sized blocks (64-bit for ASCON-128/HASH, 128-bit for ASCON-128A) and applies ASCON 10* padding.
- Presents each block to the core with a valid/ready handshake, together with per-byte valid flags and a last-block marker.

Parameters:
- RATE_WORDS_MAX, 4: maximum 32-bit words per block; sets the blk_data_o and blk_vld_byte_o widths.
- PAD_BYTE, 8'h80: byte inserted immediately after the last valid message byte.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous, active-high reset.
- clr_i  input  1  synchronous abort, e.g. on tag failure; same effect as rst_i.
- run_mode_i  input  3  ascon_cfg run mode. ASCON_128A selects 4 words per block; any other mode selects 2.
- bdi_valid_i  input  1  input word valid.
- bdi_ready_o  output  1  input word accepted when bdi_valid_i & bdi_ready_o.
- bdi_data_i  input  32  data word; byte 0 is [31:24].
- bdi_vld_byte_i  input  4  MSB-aligned byte valids: 4'hF, 4'hE, 4'hC or 4'h8.
- bdi_type_i  input  3  ascon_cfg type (D_TEXT, D_HASH, ...).
- bdi_last_i  input  1  last word of the segment.
- blk_valid_o  output  1  block available.
- blk_ready_i  input  1  core consumes the block.
- blk_data_o  output  32*RATE_WORDS_MAX  packed, padded block. First word at the MSBs; 64-bit modes use [63:0].
- blk_vld_byte_o  output  4*RATE_WORDS_MAX  message-byte valids; pad bytes are 0.
- blk_type_o  output  3  type latched from the block's first word.
- blk_last_o  output  1  final block of the segment.
- err_o  output  1  protocol error, sticky (optional feature).

Behaviour:
- Reset values (rst_i or clr_i):
  - state = FILL; word_cnt = 0.
  - bdi_ready_o = 1; blk_valid_o = 0; blk_last_o = 0.
  - blk_data_o = 0; blk_vld_byte_o = 0; blk_type_o = D_NULL; err_o = 0.
  - rst_i and clr_i have equal priority and override every other event.
- States: FILL, HOLD, PADBLK.
- FILL:
  - bdi_ready_o = 1.
  - On the first accepted word of a block, latch rate_words from run_mode_i and blk_type_o from bdi_type_i; clear the block register.
  - Accepted word k is written at word slot k. Its byte valids go to slot k of blk_vld_byte_o.
  - word_cnt increments modulo rate_words.
- Block close:
  - Condition: an accepted word with word_cnt == rate_words-1, or with bdi_last_i = 1.
  - Next cycle: HOLD, blk_valid_o = 1. Latency is 1 cycle from the closing handshake.
- Padding, when the closing word has bdi_last_i = 1:
  - Partial word (valid bytes n < 4): PAD_BYTE goes at byte n of that word.
  - Full word, not the last slot: PAD_BYTE goes at byte 0 of the next slot.
  - Full word in the last slot: no pad in this block; blk_last_o = 0, and an extra block follows.
  - All slots after the pad are 0.
  - Otherwise blk_last_o = 1.
- HOLD:
  - bdi_ready_o = 0; outputs are stable.
  - On blk_ready_i: blk_valid_o = 0. Go to PADBLK if an extra block is pending, else FILL with word_cnt = 0.
- PADBLK:
  - Takes one cycle to build the extra block: PAD_BYTE at [top byte], rest 0, blk_vld_byte_o = 0, blk_last_o = 1, same blk_type_o.
  - Then HOLD.
- No overlap: no input is accepted while blk_valid_o = 1.
- Non-last segment ending mid-block is impossible by protocol; the block only closes on bdi_last_i or a full block.
- rate_words is held constant within a block even if run_mode_i changes.

Optional Feature:
- Macro: LOAD_DATA_PROTO_CHECK_EN.
- When defined, err_o is set and stays set until rst_i/clr_i if an accepted word has any of:
  - bdi_vld_byte_i not in {F, E, C, 8};
  - bdi_vld_byte_i != F with bdi_last_i = 0;
  - word_cnt > 0 with bdi_type_i != blk_type_o.
- Data handling is unchanged when err_o is set.
- When not defined, err_o is tied to 0 and no check logic is built.

Test Plan:
1. ASCON_128, D_TEXT; words 0x11223344 (F), 0x55667788 (F,last) -> block 0x1122334455667788, vld 8'hFF, blk_last_o = 0. Next block 0x80000000_00000000, vld 0, blk_last_o = 1.
2. ASCON_128, D_HASH; one word 0xAABBCCDD (vld C, last) -> 0xAABB8000_00000000, vld 8'hC0, blk_last_o = 1, latency 1 cycle.
3. ASCON_128A; 3 full words, last -> pad at word 3 byte 0 (0x80000000), vld 16'hFFF0, blk_last_o = 1.
4. blk_ready_i held low 5 cycles -> bdi_ready_o = 0 and outputs stable throughout; the input stream resumes the cycle after blk_ready_i.
5. clr_i pulsed mid-block after 1 word -> all outputs at reset values next cycle; a new 2-word segment packs from slot 0.
6. With LOAD_DATA_PROTO_CHECK_EN: vld 4'h6 on a word -> err_o = 1 next cycle and stays 1 until clr_i.
